// File: rtl/if2dec_fifo.sv
// if2dec_fifo: decoupling FIFO between instruction fetch and decode.
//
// Payload layout (WIDTH = 97): [31:0] PC, [63:32] instruction,
// [95:64] predicted address, [96] predicted-taken flag.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   DIN_SI      payload from fetch
//   PUSH_SI     write request
//   POP_SD      read request from decode
//   FLUSH_SD    discard all contents (overrides push/pop)
//   DOUT_RI     head-entry payload (valid only while EMPTY_SI=0)
//   EMPTY_SI    no valid entry visible at the output
//   FULL_SI     occupancy == DEPTH
//   COUNT_SI    occupancy, 0..DEPTH
//   OVF_ERR_SI  sticky: push dropped while full
//   UDF_ERR_SI  sticky: pop issued while empty
//
// Optional feature: define IF2DEC_FIFO_BYPASS_EN to let a push into an empty
// FIFO appear at the output in the same cycle (and be consumed directly by a
// same-cycle pop).

module if2dec_fifo #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] DIN_SI,
  input  logic             PUSH_SI,
  input  logic             POP_SD,
  input  logic             FLUSH_SD,
  output logic [WIDTH-1:0] DOUT_RI,
  output logic             EMPTY_SI,
  output logic             FULL_SI,
  output logic [PTR_W:0]   COUNT_SI,
  output logic             OVF_ERR_SI,
  output logic             UDF_ERR_SI
);

  localparam logic [PTR_W:0] CntFull = PTR_W'(0) | (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic stored_empty;
  logic bypass;       // empty FIFO with a live push: output shows DIN_SI
  logic bypass_take;  // bypassed payload consumed by a same-cycle pop
  logic push_acc;
  logic pop_acc;

  assign stored_empty = (cnt_q == '0);

`ifdef IF2DEC_FIFO_BYPASS_EN
  assign bypass      = stored_empty && PUSH_SI && !FLUSH_SD;
`else
  assign bypass      = 1'b0;
`endif
  assign bypass_take = bypass && POP_SD;

  // Outputs: status comes from registers only, except the bypass path.
  assign EMPTY_SI   = stored_empty && !bypass;
  assign FULL_SI    = (cnt_q == CntFull);
  assign COUNT_SI   = cnt_q;
  assign DOUT_RI    = bypass ? DIN_SI : mem_q[rd_ptr_q];
  assign OVF_ERR_SI = ovf_q;
  assign UDF_ERR_SI = udf_q;

  // A full FIFO with a simultaneous pop frees the slot for the push.
  assign push_acc = PUSH_SI && (!FULL_SI || POP_SD) && !FLUSH_SD && !bypass_take;
  assign pop_acc  = POP_SD && !stored_empty && !FLUSH_SD;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (FLUSH_SD) begin
      // Flush discards any same-cycle push/pop without flagging errors.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (push_acc && !pop_acc) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop_acc && !push_acc) begin
        cnt_d = cnt_q - 1'b1;
      end

      if (PUSH_SI && FULL_SI && !POP_SD) ovf_d = 1'b1;
      if (POP_SD && EMPTY_SI)            udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_acc) begin
      mem_q[wr_ptr_q] <= DIN_SI;
    end
  end

endmodule

// File: tb/tb_if2dec_fifo.sv
// Self-checking bench for if2dec_fifo: directed scenarios followed by random
// push/pop/flush traffic, all compared against a queue-based reference model.

module tb_if2dec_fifo;

  localparam int unsigned WIDTH = 97;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] DIN_SI;
  logic             PUSH_SI;
  logic             POP_SD;
  logic             FLUSH_SD;
  logic [WIDTH-1:0] DOUT_RI;
  logic             EMPTY_SI;
  logic             FULL_SI;
  logic [PTR_W:0]   COUNT_SI;
  logic             OVF_ERR_SI;
  logic             UDF_ERR_SI;

  if2dec_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .DIN_SI     (DIN_SI),
    .PUSH_SI    (PUSH_SI),
    .POP_SD     (POP_SD),
    .FLUSH_SD   (FLUSH_SD),
    .DOUT_RI    (DOUT_RI),
    .EMPTY_SI   (EMPTY_SI),
    .FULL_SI    (FULL_SI),
    .COUNT_SI   (COUNT_SI),
    .OVF_ERR_SI (OVF_ERR_SI),
    .UDF_ERR_SI (UDF_ERR_SI)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model: a plain queue plus the two sticky flags.
  logic [WIDTH-1:0] model_q [$];
  logic             model_ovf;
  logic             model_udf;

`ifdef IF2DEC_FIFO_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_empty", WIDTH'(EMPTY_SI), WIDTH'(1));
    check_eq("rst_full",  WIDTH'(FULL_SI), WIDTH'(0));
    check_eq("rst_count", WIDTH'(COUNT_SI), WIDTH'(0));
    check_eq("rst_dout",  DOUT_RI, WIDTH'(0));
    check_eq("rst_ovf",   WIDTH'(OVF_ERR_SI), WIDTH'(0));
    check_eq("rst_udf",   WIDTH'(UDF_ERR_SI), WIDTH'(0));
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    PUSH_SI  = 1'b0;
    POP_SD   = 1'b0;
    FLUSH_SD = 1'b0;
    DIN_SI   = '0;
    reset_n  = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance model at the edge.
  task automatic step(input logic push, input logic pop, input logic flush,
                      input logic [WIDTH-1:0] din);
    logic             byp;
    logic             exp_empty;
    logic [WIDTH-1:0] exp_dout;
    int               sz;
    logic             push_ok;
    logic             pop_ok;

    PUSH_SI  = push;
    POP_SD   = pop;
    FLUSH_SD = flush;
    DIN_SI   = din;
    #1;
    sz        = model_q.size();
    byp       = BypassEn && (sz == 0) && push && !flush;
    exp_empty = (sz == 0) && !byp;
    exp_dout  = byp ? din : ((sz > 0) ? model_q[0] : '0);

    check_eq("empty", WIDTH'(EMPTY_SI), WIDTH'(exp_empty));
    check_eq("full",  WIDTH'(FULL_SI), WIDTH'(sz == DEPTH));
    check_eq("count", WIDTH'(COUNT_SI), WIDTH'(sz));
    check_eq("ovf",   WIDTH'(OVF_ERR_SI), WIDTH'(model_ovf));
    check_eq("udf",   WIDTH'(UDF_ERR_SI), WIDTH'(model_udf));
    if (!exp_empty) check_eq("dout", DOUT_RI, exp_dout);

    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else if (!(byp && pop)) begin
      pop_ok  = pop && (sz > 0);
      push_ok = push && ((sz < DEPTH) || pop);
      if (pop && sz == 0)                 model_udf = 1'b1;
      if (push && sz == DEPTH && !pop)    model_ovf = 1'b1;
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(din);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    PUSH_SI  = 1'b0;
    POP_SD   = 1'b0;
    FLUSH_SD = 1'b0;
    DIN_SI   = '0;
    @(negedge clk);

    // Reset then fill, then drain.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
    check_eq("fill_full",  WIDTH'(FULL_SI), WIDTH'(1));
    check_eq("fill_count", WIDTH'(COUNT_SI), WIDTH'(4));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Full with simultaneous push+pop, then push alone while full.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
    step(1'b1, 1'b1, 1'b0, WIDTH'(5));
    check_eq("pp_ovf", WIDTH'(OVF_ERR_SI), WIDTH'(0));
    step(1'b1, 1'b0, 1'b0, WIDTH'(6));
    check_eq("drop_ovf", WIDTH'(OVF_ERR_SI), WIDTH'(1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Underflow, then push 0xA reads back.
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("udf_set", WIDTH'(UDF_ERR_SI), WIDTH'(1));
    step(1'b1, 1'b0, 1'b0, WIDTH'('hA));
    check_eq("udf_readback", DOUT_RI, WIDTH'('hA));
    step(1'b0, 1'b1, 1'b0, '0);

    // Flush priority over push and pop.
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
    step(1'b1, 1'b1, 1'b1, WIDTH'('hB));
    check_eq("flush_empty", WIDTH'(EMPTY_SI), WIDTH'(1));
    step(1'b1, 1'b0, 1'b0, WIDTH'('hC));
    check_eq("flush_then_push", DOUT_RI, WIDTH'('hC));
    check_eq("flush_no_ovf", WIDTH'(OVF_ERR_SI), WIDTH'(0));
    step(1'b0, 1'b1, 1'b0, '0);

    // Wrap-around at occupancy 2.
    do_reset();
    step(1'b1, 1'b0, 1'b0, WIDTH'('h0E));
    step(1'b1, 1'b0, 1'b0, WIDTH'('h0F));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, WIDTH'('h10 + i));
    check_eq("wrap_count", WIDTH'(COUNT_SI), WIDTH'(2));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);

    // Push+pop on an empty FIFO (bypass when enabled, underflow otherwise).
    do_reset();
    step(1'b1, 1'b1, 1'b0, WIDTH'('hD));
    check_eq("byp_count", WIDTH'(COUNT_SI), BypassEn ? WIDTH'(0) : WIDTH'(1));
    check_eq("byp_udf",   WIDTH'(UDF_ERR_SI), BypassEn ? WIDTH'(0) : WIDTH'(1));
    step(1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-operation.
    do_reset();
    step(1'b1, 1'b0, 1'b0, WIDTH'('h77));
    step(1'b1, 1'b0, 1'b0, WIDTH'('h78));
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Random traffic, re-armed by reset so the sticky flags stay informative.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        logic [WIDTH-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 29) == 0), d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
